// File: rtl/memory_dma_pkg.sv
// Shared definitions for RAM initiators: the copy-engine state encoding.
package memory_dma_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/memory_dma.sv
// Block-copy engine driving a single-port synchronous RAM with one-cycle read latency.
// Each word takes READ, CAPTURE, WRITE; all outputs are registered.
module memory_dma
  import memory_dma_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [ADDRESS_BITS-1:0] SRC_ADDR,
  input  logic [ADDRESS_BITS-1:0] DST_ADDR,
  input  logic [ADDRESS_BITS-1:0] COUNT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_DATA_OUT,
  input  logic [BITS-1:0]         MEM_DATA_IN,
  output logic                    MEM_WRb
);

  localparam logic [ADDRESS_BITS-1:0] ONE = ADDRESS_BITS'(1);

  state_t                  state, state_d;
  logic [ADDRESS_BITS-1:0] src_q, src_d;
  logic [ADDRESS_BITS-1:0] dst_q, dst_d;
  logic [ADDRESS_BITS-1:0] remaining_q, remaining_d;
  logic                    busy_d, done_d, wrb_d;
  logic [ADDRESS_BITS-1:0] addr_d;
  logic [BITS-1:0]         data_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      MEM_ADDRESS  <= '0;
      MEM_DATA_OUT <= '0;
      MEM_WRb      <= 1'b1;
    end else begin
      state        <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
      MEM_ADDRESS  <= addr_d;
      MEM_DATA_OUT <= data_d;
      MEM_WRb      <= wrb_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (START && COUNT != '0) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = (remaining_q == ONE) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and copy counters.
  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    addr_d      = MEM_ADDRESS;
    data_d      = MEM_DATA_OUT;
    wrb_d       = 1'b1;
    done_d      = 1'b0;
    busy_d      = (state_d != IDLE);
    unique case (state)
      IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            src_d       = SRC_ADDR;
            dst_d       = DST_ADDR;
            remaining_d = COUNT;
            addr_d      = SRC_ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: addr_d = src_q;
      CAPTURE: begin
        // Read data is valid this cycle; launch the write on the next one.
        data_d = MEM_DATA_IN;
        addr_d = dst_q;
        wrb_d  = 1'b0;
      end
      WRITE: begin
        src_d       = src_q + ONE;
        dst_d       = dst_q + ONE;
        remaining_d = remaining_q - ONE;
        if (remaining_q == ONE) done_d = 1'b1;
        else                    addr_d = src_q + ONE;
      end
      default: ;
    endcase
  end

endmodule
